pc_gen: RTL
===========

// Module: pc_gen
// PURPOSE
//  Program-counter generator for the fetch stage; drives the 32-bit pc_out stream to the fetch side.
//  Sequences through boot delay, sequential fetch (+4), branch/trap redirects, and debug halt/resume.
//  Produces flush and misalignment flags, plus an accepted-fetch counter for the monitor/scoreboard.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  pc_out value at reset and first fetched address
//  TRAP_VECTOR   32'h0000_0100  redirect address for trap_req and misaligned branch targets
//  BOOT_DELAY    2              extra idle cycles after reset release before pc_valid rises (0..255)
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  fetch_ready    in   1   fetch side accepts pc_out this cycle
//  branch_taken   in   1   redirect request from execute
//  branch_target  in   32  redirect address, qualified by branch_taken
//  trap_req       in   1   exception/trap redirect request
//  halt_req       in   1   debug halt request
//  resume         in   1   leave HALTED
//  pc_out         out  32  current fetch address
//  pc_valid       out  1   pc_out is a valid fetch request
//  flush          out  1   one-cycle pulse: pc_out was redirected
//  misalign       out  1   one-cycle pulse: branch_target[1:0] != 0
//  bad_target     out  32  last misaligned branch_target (sticky)
//  halted         out  1   high while in HALTED
//  fetch_count    out  32  number of accepted fetches (pc_valid & fetch_ready)
// BEHAVIOUR
//  Reset (async, immediate, no clock needed):
//   - pc_out = RESET_VECTOR; pc_valid, flush, misalign, halted = 0; bad_target, fetch_count = 0.
//   - State = BOOT with boot counter = 0.
//  States: BOOT, RUN, HALTED. All outputs are registered.
//  BOOT:
//   - The boot counter increments each cycle; pc_valid = 0.
//   - All inputs are ignored.
//   - When the counter equals BOOT_DELAY, go to RUN. pc_valid rises at edge BOOT_DELAY+1 after rst_n deassertion.
//  RUN, per-edge priority (highest first):
//   1. trap_req: pc_out <= TRAP_VECTOR; flush <= 1.
//   2. branch_taken & target[1:0] != 0: pc_out <= TRAP_VECTOR; flush <= 1; misalign <= 1; bad_target <= target.
//   3. branch_taken (aligned): pc_out <= branch_target; flush <= 1.
//   4. pc_valid & fetch_ready: pc_out <= pc_out + 4, mod 2^32 (0xFFFF_FFFC wraps to 0).
//   5. Otherwise hold pc_out.
//   - halt_req (evaluated after 1-5 in the same edge): go to HALTED; pc_valid <= 0; halted <= 1.
//   - fetch_count increments on every pc_valid & fetch_ready, including redirect cycles; wraps at 2^32.
//  Handshake:
//   - While pc_valid & !fetch_ready, pc_out stays stable unless a redirect (1-3) occurs.
//   - A redirect cancels the unaccepted request; fetch treats the old address as squashed.
//   - flush and misalign deassert the cycle after their pulse unless re-triggered.
//  HALTED:
//   - pc_valid = 0; pc_out held.
//   - branch_taken, trap_req and fetch_ready are ignored.
//   - resume: go to RUN, with pc_valid = 1 and halted = 0 on the next edge; the same pc_out is re-issued.
//  Simultaneous halt_req & resume: in RUN, halt wins; in HALTED, resume wins.
//  rst_n asserted mid-operation: all state returns to reset values at once; BOOT restarts on release.
// TESTING
//  1. Release rst_n, BOOT_DELAY=2, fetch_ready=1 -> pc_valid rises at edge 3; pc_out 0x0,0x4,0x8; fetch_count 1,2,3.
//  2. At pc_out=0x10, fetch_ready=0 for 3 cycles -> pc_out stays 0x10, fetch_count unchanged, no flush.
//  3. branch_taken=1, target=0x200, fetch_ready=0 -> next cycle pc_out=0x200, flush high exactly 1 cycle.
//  4. target=0x202 -> pc_out=0x100, misalign pulse, bad_target=0x202.
//     trap_req and branch(0x300) in the same cycle -> pc_out=0x100.
//  5. halt_req at pc_out=0x40, fetch_ready=0 -> halted=1, pc_valid=0, branch ignored.
//     Then resume -> pc_valid=1, pc_out=0x40.
//  6. branch to 0xFFFF_FFFC, accept -> pc_out=0x0.
//     Drop rst_n between clock edges -> outputs reset immediately.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: boot delay, sequential +4 fetch,
// branch/trap redirects with misalignment trapping, and debug halt/resume.
module pc_gen #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned BOOT_DELAY   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_ready,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        trap_req,
   input  logic        halt_req,
   input  logic        resume,
   output logic [31:0] pc_out,
   output logic        pc_valid,
   output logic        flush,
   output logic        misalign,
   output logic [31:0] bad_target,
   output logic        halted,
   output logic [31:0] fetch_count
);

   localparam logic [1:0] ST_BOOT   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   localparam logic [7:0] BOOT_LAST = 8'(BOOT_DELAY);

   logic [1:0] state;
   logic [7:0] boot_cnt;
   logic       accept;

   assign accept = pc_valid & fetch_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_BOOT;
         boot_cnt    <= '0;
         pc_out      <= RESET_VECTOR;
         pc_valid    <= 1'b0;
         flush       <= 1'b0;
         misalign    <= 1'b0;
         bad_target  <= '0;
         halted      <= 1'b0;
         fetch_count <= '0;
      end else begin
         flush    <= 1'b0;
         misalign <= 1'b0;
         case (state)
            ST_BOOT: begin
               if (boot_cnt == BOOT_LAST) begin
                  state    <= ST_RUN;
                  pc_valid <= 1'b1;
               end else begin
                  boot_cnt <= boot_cnt + 8'd1;
               end
            end
            ST_RUN: begin
               if (accept)
                  fetch_count <= fetch_count + 32'd1;
               // Redirects override the +4 step; an unaccepted request is squashed.
               if (trap_req) begin
                  pc_out <= TRAP_VECTOR;
                  flush  <= 1'b1;
               end else if (branch_taken && (branch_target[1:0] != 2'b00)) begin
                  pc_out     <= TRAP_VECTOR;
                  flush      <= 1'b1;
                  misalign   <= 1'b1;
                  bad_target <= branch_target;
               end else if (branch_taken) begin
                  pc_out <= branch_target;
                  flush  <= 1'b1;
               end else if (accept) begin
                  pc_out <= pc_out + 32'd4;
               end
               if (halt_req) begin
                  state    <= ST_HALTED;
                  pc_valid <= 1'b0;
                  halted   <= 1'b1;
               end
            end
            ST_HALTED: begin
               if (resume) begin
                  state    <= ST_RUN;
                  pc_valid <= 1'b1;
                  halted   <= 1'b0;
               end
            end
            default: begin
               state    <= ST_BOOT;
               boot_cnt <= '0;
               pc_valid <= 1'b0;
               halted   <= 1'b0;
            end
         endcase
      end
   end

endmodule
